// File: rtl/ser_frame_transmitter.sv
// Serial frame receiver/forwarder: start bit, MSB-first length field, payload
// bits forwarded one per strobe, optional trailing parity bit checked at the end.
module ser_frame_transmitter #(
    parameter int CNT_W      = 4,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_pulse,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic [CNT_W-1:0] cnt_out,
    output logic             busy,
    output logic             done,
    output logic             parity_err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PAR  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] len_reg, len_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             acc_reg, acc_next;
    logic             out_reg, out_next;
    logic             valid_reg, valid_next;
    logic             perr_reg, perr_next;
    logic [CNT_W-1:0] len_shifted;

    // Length field arrives MSB first: shift left, new bit enters at bit 0.
    assign len_shifted[0] = ser_in;
    for (genvar gi = 1; gi < CNT_W; gi++) begin : g_len_shift
        assign len_shifted[gi] = len_reg[gi-1];
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        out_next   = out_reg;
        valid_next = 1'b0;
        perr_next  = perr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_pulse && !ser_in) begin
                    state_next = ST_LEN;
                    len_next   = '0;
                    idx_next   = '0;
                    perr_next  = 1'b0;
                end
            end
            ST_LEN: begin
                if (in_pulse) begin
                    len_next = len_shifted;
                    if (idx_reg == IDX_W'(CNT_W-1)) begin
                        cnt_next   = len_shifted;
                        acc_next   = 1'b0;
                        idx_next   = '0;
                        // Empty frame skips the parity bit entirely.
                        state_next = (len_shifted == '0) ? ST_DONE : ST_DATA;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (in_pulse) begin
                    out_next   = ser_in;
                    valid_next = 1'b1;
                    cnt_next   = cnt_reg - 1'b1;
                    acc_next   = acc_reg ^ ser_in;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_next = PARITY_EN ? ST_PAR : ST_DONE;
                    end
                end
            end
            ST_PAR: begin
                if (in_pulse) begin
                    perr_next  = ser_in ^ acc_reg ^ PARITY_ODD;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            acc_reg   <= 1'b0;
            out_reg   <= 1'b0;
            valid_reg <= 1'b0;
            perr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            perr_reg  <= perr_next;
        end
    end

    assign ser_out       = out_reg;
    assign ser_out_valid = valid_reg;
    assign cnt_out       = cnt_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign parity_err    = perr_reg;

endmodule

// File: tb/tb_ser_frame_transmitter.sv
// Bench for ser_frame_transmitter: three instances (no parity, even, odd),
// a vector table, hand-written corner sequences and random frames.
module tb_ser_frame_transmitter;

    logic clk;
    logic rst;
    logic in_pulse_a [3];
    logic ser_in_a   [3];
    wire        so_a    [3];
    wire        valid_a [3];
    wire  [3:0] cnt_a   [3];
    wire        busy_a  [3];
    wire        done_a  [3];
    wire        perr_a  [3];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_perr [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        ser_frame_transmitter #(
            .CNT_W      (4),
            .PARITY_EN  (gi > 0),
            .PARITY_ODD (gi == 2)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .in_pulse      (in_pulse_a[gi]),
            .ser_in        (ser_in_a[gi]),
            .ser_out       (so_a[gi]),
            .ser_out_valid (valid_a[gi]),
            .cnt_out       (cnt_a[gi]),
            .busy          (busy_a[gi]),
            .done          (done_a[gi]),
            .parity_err    (perr_a[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ip;
        logic si;
        int   v;
        int   o;
        int   c;
        int   b;
        int   d;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input int sel, input string tag, input int v, input int o,
                           input int c, input int b, input int d);
        chk($sformatf("%s[%0d].valid", tag, sel), int'(valid_a[sel]), v);
        if (o >= 0) chk($sformatf("%s[%0d].ser_out", tag, sel), int'(so_a[sel]), o);
        if (c >= 0) chk($sformatf("%s[%0d].cnt_out", tag, sel), int'(cnt_a[sel]), c);
        chk($sformatf("%s[%0d].busy", tag, sel), int'(busy_a[sel]), b);
        chk($sformatf("%s[%0d].done", tag, sel), int'(done_a[sel]), d);
    endtask

    task automatic chk_perr(input int sel, input string tag);
        chk($sformatf("%s[%0d].parity_err", tag, sel), int'(perr_a[sel]), exp_perr[sel]);
    endtask

    // Drive one cycle on one instance; returns 1 time unit after the edge.
    task automatic step(input int sel, input logic ip, input logic si);
        in_pulse_a[sel] = ip;
        ser_in_a[sel]   = si;
        @(posedge clk);
        #1;
        in_pulse_a[sel] = 1'b0;
        ser_in_a[sel]   = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_perr[k] = 0;
    endtask

    task automatic gaps(input int sel, input int gapmax, input int b);
        int n;
        n = int'($urandom_range(0, gapmax));
        for (int k = 0; k < n; k++) begin
            step(sel, 1'b0, 1'($urandom_range(0, 1)));
            chk_all(sel, "gap", 0, -1, -1, b, 0);
        end
    endtask

    // Expected behaviour derived from the frame content itself.
    task automatic send_frame(input int sel, input int len, input logic [14:0] data,
                              input logic pbit, input int gapmax);
        int         pe;
        int         odd;
        int         par;
        int         n_idle;
        logic [3:0] lv;
        pe     = (sel > 0) ? 1 : 0;
        odd    = (sel == 2) ? 1 : 0;
        par    = 0;
        lv     = 4'(len);
        n_idle = int'($urandom_range(0, 2));
        for (int k = 0; k < n_idle; k++) begin
            step(sel, 1'b1, 1'b1);
            chk_all(sel, "idle1", 0, -1, -1, 0, 0);
            chk_perr(sel, "idle1");
        end
        gaps(sel, gapmax, 0);
        step(sel, 1'b1, 1'b0);
        exp_perr[sel] = 0;
        chk_all(sel, "start", 0, -1, -1, 1, 0);
        chk_perr(sel, "start");
        for (int i = 3; i >= 0; i--) begin
            gaps(sel, gapmax, 1);
            step(sel, 1'b1, lv[i]);
            chk_all(sel, "len", 0, -1, (i == 0) ? len : -1, 1,
                    (i == 0 && len == 0) ? 1 : 0);
        end
        for (int j = 0; j < len; j++) begin
            gaps(sel, gapmax, 1);
            step(sel, 1'b1, data[j]);
            par = par ^ int'(data[j]);
            chk_all(sel, "data", 1, int'(data[j]), len - 1 - j, 1,
                    (j == len - 1 && pe == 0) ? 1 : 0);
        end
        if (pe == 1 && len > 0) begin
            gaps(sel, gapmax, 1);
            step(sel, 1'b1, pbit);
            exp_perr[sel] = (int'(pbit) != (par ^ odd)) ? 1 : 0;
            chk_all(sel, "par", 0, -1, 0, 1, 1);
            chk_perr(sel, "par");
        end
        // A strobe with ser_in=0 here must not start a frame from DONE.
        step(sel, 1'($urandom_range(0, 1)), 1'b0);
        chk_all(sel, "end", 0, -1, 0, 0, 0);
        chk_perr(sel, "end");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_pulse_a[k] = 1'b0;
            ser_in_a[k]   = 1'b1;
            exp_perr[k]   = 0;
        end
        for (int k = 0; k < 5; k++) vecs[k] = '{1'b1, 1'b1, 0, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 0, 0, 0, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 0, 0, 0, 1, 0};
        vecs[7]  = '{1'b1, 1'b0, 0, 0, 0, 1, 0};
        vecs[8]  = '{1'b1, 1'b1, 0, 0, 0, 1, 0};
        vecs[9]  = '{1'b1, 1'b1, 0, 0, 3, 1, 0};
        vecs[10] = '{1'b1, 1'b1, 1, 1, 2, 1, 0};
        vecs[11] = '{1'b1, 1'b0, 1, 0, 1, 1, 0};
        vecs[12] = '{1'b1, 1'b1, 1, 1, 0, 1, 1};
        vecs[13] = '{1'b0, 1'b1, 0, 1, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_all(k, "reset", 0, 0, 0, 0, 0);
            chk_perr(k, "reset");
        end

        for (int i = 0; i < 14; i++) begin
            step(0, vecs[i].ip, vecs[i].si);
            chk_all(0, $sformatf("vec%0d", i), vecs[i].v, vecs[i].o, vecs[i].c,
                    vecs[i].b, vecs[i].d);
        end

        // Reset in DATA with cnt_out=5 aborts the frame.
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1);
        chk_all(0, "pre_abort", 1, 1, 5, 1, 0);
        rst = 1'b1;
        step(0, 1'b1, 1'b1);
        rst = 1'b0;
        chk_all(0, "abort", 0, 0, 0, 0, 0);
        chk_perr(0, "abort");
        step(0, 1'b0, 1'b1);
        chk_all(0, "post_abort", 0, 0, 0, 0, 0);

        // Empty frame with parity enabled, maximum length, parity pass/fail.
        send_frame(1, 0, 15'h0000, 1'b1, 0);
        send_frame(0, 15, 15'h5a3c, 1'b0, 0);
        send_frame(1, 2, 15'h0003, 1'b0, 0);
        send_frame(1, 2, 15'h0003, 1'b1, 0);
        step(1, 1'b0, 1'b1);
        chk_perr(1, "hold_a");
        step(1, 1'b1, 1'b1);
        chk_perr(1, "hold_b");
        step(1, 1'b1, 1'b0);
        exp_perr[1] = 0;
        chk_perr(1, "clear");
        chk_all(1, "clear", 0, -1, -1, 1, 0);
        do_reset();

        for (int r = 0; r < 40; r++) begin
            send_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                       15'($urandom), 1'($urandom_range(0, 1)), 2);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
